// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and pointer-code helpers for the async FIFO
//               control stages (write side and read side).
//               - c_FIFO_ADDR_SIZE / c_DEPTH : default RAM geometry
//               - depth_of()   : DEPTH for a given address width
//               - bin2gray()   : binary -> reflected Gray code
//               - gray2bin()   : reflected Gray code -> binary
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_FIFO_ADDR_SIZE = 5;
    localparam int c_DEPTH          = 2 ** c_FIFO_ADDR_SIZE;

    // Widest pointer the helpers handle. Both conversions are insensitive to
    // zero-extension (leading zeros map to leading zeros), so callers of any
    // width up to this zero-extend on the way in and take their low bits back.
    localparam int c_PTR_MAX_W = 32;

    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

    function automatic logic [c_PTR_MAX_W-1:0] bin2gray(input logic [c_PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above its position.
    function automatic logic [c_PTR_MAX_W-1:0] gray2bin(input logic [c_PTR_MAX_W-1:0] gray);
        logic [c_PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < c_PTR_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_ff
// Description : Multi-flop synchroniser for a Gray-coded pointer crossing
//               into the local clock domain. Every stage resets to zero.
// Ports       : clk   - destination-domain clock
//               rst_n - asynchronous, active-low reset
//               d     - pointer from the source domain (registered there)
//               q     - pointer after STAGES destination-domain flops
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] r_q;
            logic [WIDTH-1:0] w_d;

            if (gi == 0) begin : g_first
                assign w_d = d;
            end else begin : g_next
                assign w_d = g_stage[gi-1].r_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_d;
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].r_q;

endmodule : fifo_sync_ff
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-domain control stage of the async FIFO. Owns the binary
//               write pointer, drives the RAM write address, synchronises the
//               read-side Gray pointer into clk_w and derives a pessimistic
//               fill level plus full / almost_full flags.
// Ports       : clk_w       - write clock
//               rst_w       - asynchronous, active-low reset
//               w_en        - producer write request
//               r_gray_ptr  - read pointer, Gray coded, from clk_r domain
//               w_addr      - RAM write address (low bits of write pointer)
//               w_gray_ptr  - registered Gray write pointer for read side
//               full        - registered, FIFO holds DEPTH words
//               almost_full - registered, level >= DEPTH-AF_MARGIN (advisory)
//               w_level     - registered fill level (stale read pointer)
//               w_accept    - combinational, write takes effect this edge
//               w_drop      - registered pulse, write requested while full
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_ADDR_SIZE = c_FIFO_ADDR_SIZE,  // 1..30
    parameter int AF_MARGIN      = 2,                 // 1..DEPTH-1
    parameter int SYNC_STAGES    = 2                  // >= 2
) (
    input  logic                      clk_w,
    input  logic                      rst_w,
    input  logic                      w_en,
    input  logic [FIFO_ADDR_SIZE:0]   r_gray_ptr,
    output logic [FIFO_ADDR_SIZE-1:0] w_addr,
    output logic [FIFO_ADDR_SIZE:0]   w_gray_ptr,
    output logic                      full,
    output logic                      almost_full,
    output logic [FIFO_ADDR_SIZE:0]   w_level,
    output logic                      w_accept,
    output logic                      w_drop
);

    // Pointers carry one extra wrap bit so that full and empty differ.
    localparam int                 c_PTR_W      = FIFO_ADDR_SIZE + 1;
    localparam int                 c_FIFO_DEPTH = depth_of(FIFO_ADDR_SIZE);
    localparam logic [c_PTR_W-1:0] c_FULL_LEVEL = c_PTR_W'(c_FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_AF_LEVEL   = c_PTR_W'(c_FIFO_DEPTH - AF_MARGIN);

    logic [c_PTR_W-1:0]     r_wbin;
    logic [c_PTR_W-1:0]     r_gray;
    logic                   r_full;
    logic                   r_almost_full;
    logic [c_PTR_W-1:0]     r_level;
    logic                   r_drop;

    logic                   w_accept_int;
    logic [c_PTR_W-1:0]     w_wbin_next;
    logic [c_PTR_W-1:0]     w_rq_gray;
    logic [c_PTR_W-1:0]     w_rbin_s;
    logic [c_PTR_W-1:0]     w_level_next;
    logic [c_PTR_MAX_W-1:0] w_gray_full;
    logic [c_PTR_MAX_W-1:0] w_rbin_full;
    logic                   w_unused_hi;

    // Read pointer into clk_w; only registered state ever sees it, so there
    // is no combinational path from r_gray_ptr to an output.
    fifo_sync_ff #(
        .WIDTH  (c_PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (clk_w),
        .rst_n (rst_w),
        .d     (r_gray_ptr),
        .q     (w_rq_gray)
    );

    assign w_accept_int = w_en & ~r_full;
    assign w_wbin_next  = r_wbin + c_PTR_W'(w_accept_int);

    assign w_gray_full  = bin2gray(c_PTR_MAX_W'(w_wbin_next));
    assign w_rbin_full  = gray2bin(c_PTR_MAX_W'(w_rq_gray));
    assign w_rbin_s     = w_rbin_full[c_PTR_W-1:0];
    assign w_unused_hi  = ^{w_gray_full[c_PTR_MAX_W-1:c_PTR_W], w_rbin_full[c_PTR_MAX_W-1:c_PTR_W]};

    // Modular subtraction; a write and a synced read on the same edge both
    // land here, so they cancel in the level without special casing.
    assign w_level_next = w_wbin_next - w_rbin_s;

    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            r_wbin        <= '0;
            r_gray        <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_gray        <= w_gray_full[c_PTR_W-1:0];
            // Level never exceeds DEPTH, so equality is the Gray full test
            // (top two bits inverted, remainder equal) in binary form.
            r_full        <= (w_level_next == c_FULL_LEVEL);
            r_almost_full <= (w_level_next >= c_AF_LEVEL);
            r_level       <= w_level_next;
            r_drop        <= w_en & r_full;
        end
    end

    assign w_addr      = r_wbin[FIFO_ADDR_SIZE-1:0];
    assign w_gray_ptr  = r_gray;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign w_level     = r_level;
    assign w_accept    = w_accept_int;
    assign w_drop      = r_drop;

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Self-checking bench for fifo_wr_ctrl. A word-count model of
//               the FIFO predicts every cycle's outputs into a scoreboard
//               queue; a monitor pops and compares each cycle. Directed
//               scenarios cover reset, fill, drain, wrap, simultaneous
//               write/read and mid-operation reset, followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    localparam int c_AW    = 5;
    localparam int c_PW    = c_AW + 1;
    localparam int c_DEPTH = 32;
    localparam int c_AFM   = 2;
    localparam int c_SYNC  = 2;

    logic            clk_w      = 1'b0;
    logic            rst_w      = 1'b0;
    logic            w_en       = 1'b0;
    logic [c_PW-1:0] r_gray_ptr = '0;
    logic [c_AW-1:0] w_addr;
    logic [c_PW-1:0] w_gray_ptr;
    logic            full;
    logic            almost_full;
    logic [c_PW-1:0] w_level;
    logic            w_accept;
    logic            w_drop;

    always #5 clk_w = ~clk_w;

    fifo_wr_ctrl #(
        .FIFO_ADDR_SIZE (c_AW),
        .AF_MARGIN      (c_AFM),
        .SYNC_STAGES    (c_SYNC)
    ) dut (
        .clk_w       (clk_w),
        .rst_w       (rst_w),
        .w_en        (w_en),
        .r_gray_ptr  (r_gray_ptr),
        .w_addr      (w_addr),
        .w_gray_ptr  (w_gray_ptr),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .w_accept    (w_accept),
        .w_drop      (w_drop)
    );

    typedef struct packed {
        logic [c_AW-1:0] addr;
        logic [c_PW-1:0] gray;
        logic            full;
        logic            af;
        logic [c_PW-1:0] level;
        logic            drop;
        logic            accept;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Model: total words accepted since reset, read counts as seen after the
    // synchroniser delay, and the flags as they stand after the last edge.
    int m_wcnt;
    int m_seen[$];
    int m_level;
    bit m_full;
    bit m_af;
    bit m_drop;
    int rd_cnt;

    function automatic logic [c_PW-1:0] gray_of(input int n);
        int b;
        b = n % (2 * c_DEPTH);
        return c_PW'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt  = 0;
        m_seen  = {};
        for (int i = 0; i < c_SYNC; i++) m_seen.push_back(0);
        m_level = 0;
        m_full  = 1'b0;
        m_af    = 1'b0;
        m_drop  = 1'b0;
        rd_cnt  = 0;
    endtask

    task automatic push_expect(input bit we);
        exp_t e;
        e.addr   = c_AW'(m_wcnt % c_DEPTH);
        e.gray   = gray_of(m_wcnt);
        e.full   = m_full;
        e.af     = m_af;
        e.level  = c_PW'(m_level);
        e.drop   = m_drop;
        e.accept = we && !m_full;
        sb.push_back(e);
    endtask

    // One clk_w cycle: drive at the falling edge, predict, advance the model.
    task automatic cycle(input bit we, input int rd);
        bit acc;
        int seen;
        @(negedge clk_w);
        w_en       = we;
        rd_cnt     = rd;
        r_gray_ptr = gray_of(rd);
        push_expect(we);
        acc     = we && !m_full;
        seen    = m_seen.pop_front();
        m_seen.push_back(rd);
        m_wcnt  = m_wcnt + (acc ? 1 : 0);
        m_level = m_wcnt - seen;
        m_drop  = we && m_full;
        m_full  = (m_level == c_DEPTH);
        m_af    = (m_level >= c_DEPTH - c_AFM);
    endtask

    // Assert reset in the middle of the high phase, away from any edge.
    task automatic pulse_reset(input int hold);
        @(posedge clk_w);
        #3;
        rst_w      = 1'b0;
        w_en       = 1'b0;
        r_gray_ptr = '0;
        model_reset();
        #1;
        chk("rst_async_level", 32'(w_level), 0);
        chk("rst_async_gray", 32'(w_gray_ptr), 0);
        chk("rst_async_full", 32'(full), 0);
        push_expect(1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_w);
            push_expect(1'b0);
        end
        @(posedge clk_w);
        #3;
        rst_w = 1'b1;
    endtask

    task automatic post_edge();
        @(posedge clk_w);
        #1;
    endtask

    // Monitor: compare every queued prediction against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_w);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("w_addr", 32'(w_addr), 32'(e.addr));
                chk("w_gray_ptr", 32'(w_gray_ptr), 32'(e.gray));
                chk("full", 32'(full), 32'(e.full));
                chk("almost_full", 32'(almost_full), 32'(e.af));
                chk("w_level", 32'(w_level), 32'(e.level));
                chk("w_drop", 32'(w_drop), 32'(e.drop));
                chk("w_accept", 32'(w_accept), 32'(e.accept));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [c_PW-1:0] prev_gray;
        int rd;
        bit we;
        bit rinc;

        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_w);
            push_expect(1'b0);
        end
        @(posedge clk_w);
        #3;
        rst_w = 1'b1;

        // Some traffic, then an asynchronous reset in mid-cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, 0);
        pulse_reset(2);

        // Fill with the read pointer parked at zero.
        for (int i = 0; i < c_DEPTH; i++) begin
            cycle(1'b1, 0);
            if (i == c_DEPTH - c_AFM - 1) begin
                post_edge();
                chk("fill30_af", 32'(almost_full), 1);
                chk("fill30_level", 32'(w_level), 30);
                chk("fill30_full", 32'(full), 0);
            end
        end
        post_edge();
        chk("fill32_full", 32'(full), 1);
        chk("fill32_addr", 32'(w_addr), 0);
        chk("fill32_gray", 32'(w_gray_ptr), 32'b110000);
        cycle(1'b1, 0);
        post_edge();
        chk("drop_pulse", 32'(w_drop), 1);
        chk("drop_addr", 32'(w_addr), 0);
        chk("drop_level", 32'(w_level), 32);
        cycle(1'b0, 0);
        post_edge();
        chk("drop_clear", 32'(w_drop), 0);

        // Drain: read pointer jumps to 32 (Gray 110000).
        cycle(1'b0, c_DEPTH);
        cycle(1'b0, c_DEPTH);
        post_edge();
        chk("drain_2edges_full", 32'(full), 1);
        cycle(1'b0, c_DEPTH);
        post_edge();
        chk("drain_full", 32'(full), 0);
        chk("drain_af", 32'(almost_full), 0);
        chk("drain_level", 32'(w_level), 0);

        // Wrap: 70 writes while the reader keeps up.
        prev_gray = w_gray_ptr;
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, m_wcnt);
            #2;
            chk("wrap_addr_seq", 32'(w_addr), 32'(i % c_DEPTH));
            post_edge();
            chk("wrap_gray_hamming", 32'($countones(prev_gray ^ w_gray_ptr)), 1);
            prev_gray = w_gray_ptr;
        end

        // Simultaneous write and synced read at level 31.
        rd = m_wcnt;
        for (int i = 0; i < 3; i++) cycle(1'b0, rd);
        for (int i = 0; i < 31; i++) cycle(1'b1, rd);
        cycle(1'b0, rd + 1);
        cycle(1'b0, rd + 1);
        post_edge();
        chk("sim_pre_level", 32'(w_level), 31);
        cycle(1'b1, rd + 1);
        post_edge();
        chk("sim_level", 32'(w_level), 31);
        chk("sim_full", 32'(full), 0);

        // Mid-operation reset at level 17.
        rd = m_wcnt;
        for (int i = 0; i < 3; i++) cycle(1'b0, rd);
        for (int i = 0; i < 17; i++) cycle(1'b1, rd);
        post_edge();
        chk("pre_rst_level", 32'(w_level), 17);
        pulse_reset(1);
        cycle(1'b1, 0);
        #2;
        chk("first_wr_addr", 32'(w_addr), 0);
        post_edge();
        chk("first_wr_gray", 32'(w_gray_ptr), 32'b000001);

        // Random traffic, write-heavy then read-heavy, with a reset between.
        for (int i = 0; i < 300; i++) begin
            we   = ($urandom_range(0, 99) < 65);
            rinc = ($urandom_range(0, 99) < 45) && (rd_cnt < m_wcnt);
            cycle(we, rd_cnt + (rinc ? 1 : 0));
        end
        pulse_reset(1);
        for (int i = 0; i < 200; i++) begin
            we   = ($urandom_range(0, 99) < 40);
            rinc = ($urandom_range(0, 99) < 70) && (rd_cnt < m_wcnt);
            cycle(we, rd_cnt + (rinc ? 1 : 0));
        end
        cycle(1'b0, rd_cnt);

        @(negedge clk_w);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire
